zombie_layer: RTL and testbench
===============================

ZOMBIE_LAYER -- requirements
Module: zombie_layer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ZOM_W, 64, sprite width in pixels
- ZOM_H, 80, sprite height in pixels
- START_X, 640, spawn x position
- END_X, 40, x at or below which the zombie has reached the house
- ROW_Y0, 80, y of row 0
- ROW_PITCH, 96, y spacing between rows
- STEP_FRAMES, 4, frames per 1-pixel step
- HP_INIT, 10, hits needed to kill
- DEAD_FRAMES, 30, frames spent in DYING
REQ-002 Ports, one per line: name, direction, width, meaning.
- CLK, in, 1, pixel-domain clock
- Reset_h, in, 1, asynchronous reset, active-high
- frame_start, in, 1, one-cycle pulse per frame
- DrawX, in, 10, current pixel x
- DrawY, in, 10, current pixel y
- spawn, in, 1, spawn request pulse
- spawn_row, in, 3, row for spawn, 0-4
- hit, in, 1, one-cycle pea hit pulse
- blocked, in, 1, level; a plant occupies the cell in front
- read_address_zom, out, 19, sprite ROM address
- zom_on, out, 1, layer-valid to Color_Mapper, aligned with ROM data
- zom_x, out, 10, current x
- zom_row, out, 3, current row
- zom_state, out, 2, 0 IDLE, 1 WALK, 2 EAT, 3 DYING
- reached_end, out, 1, sticky game-over flag (drives END_on)

Function
REQ-003 The FSM SHALL have states IDLE, WALK, EAT and DYING, with all registers clocked on the rising edge of CLK.
REQ-004 In IDLE, spawn with spawn_row<=4 SHALL load zom_x=START_X, zom_row=spawn_row, hp=HP_INIT and step_cnt=0, and enter WALK; spawn_row>4 and spawn in any other state SHALL be ignored.
REQ-005 In WALK, each frame_start SHALL increment step_cnt; when step_cnt==STEP_FRAMES-1, zom_x SHALL decrement by 1 and step_cnt SHALL clear.
REQ-006 In WALK with blocked=1, the FSM SHALL enter EAT on the next edge, and step_cnt SHALL hold with no movement.
REQ-007 In EAT with blocked=0, the FSM SHALL return to WALK, resuming from the held step_cnt.
REQ-008 In WALK or EAT, hit SHALL decrement hp by 1; a hit that makes hp 0 SHALL enter DYING and take priority over blocked and over movement in the same cycle.
REQ-009 In DYING, hits SHALL be ignored; DYING SHALL count DEAD_FRAMES frame_start pulses, then enter IDLE.
REQ-010 When zom_x<=END_X in WALK, reached_end SHALL set and stay set until reset, and the FSM SHALL enter IDLE.
REQ-011 hit and frame_start in the same cycle SHALL both take effect.
REQ-012 The module SHALL compute the bounding box as row_y = ROW_Y0 + zom_row*ROW_PITCH.
REQ-013 A pixel is inside the box when zom_x<=DrawX<zom_x+ZOM_W and row_y<=DrawY<row_y+ZOM_H; the comparisons SHALL use 11 bits so that zom_x+ZOM_W>=640 does not wrap.
REQ-014 read_address_zom SHALL be (DrawY-row_y)*ZOM_W + (DrawX-zom_x) + base, registered 1 cycle after DrawX/DrawY.
REQ-015 base SHALL be 0 in WALK and DYING and ZOM_W*ZOM_H in EAT.
REQ-016 read_address_zom SHALL be 0 when the pixel is outside the box.
REQ-017 zom_on SHALL be 1 only when the pixel is in the box and the state is not IDLE, delayed 2 cycles from DrawX/DrawY to match the 1-cycle synchronous ROM.

Reset
REQ-018 Reset_h=1 SHALL immediately force state IDLE, zom_x=0, zom_row=0, hp=0, step_cnt=0, reached_end=0, zom_on=0 and read_address_zom=0, including in mid-walk or mid-DYING.
REQ-019 The module SHALL resume normal operation on the first CLK edge after Reset_h deasserts.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Spawn with spawn_row=2, then 8 frame_start pulses -> WALK, zom_x=638, zom_row=2.
- Walking, blocked=1 for 10 frames -> EAT, zom_x unchanged, address base=5120; blocked=0 -> WALK and movement resumes.
- 10 hits -> DYING on the 10th; after 30 frame_start pulses -> IDLE; an 11th hit has no effect.
- zom_x=600, zom_row=0, DrawX=610, DrawY=90 -> read_address_zom=650 at +1 cycle, zom_on=1 at +2 cycles; DrawX=599 -> zom_on=0.
- Walk to zom_x=40 -> reached_end=1 and IDLE; a later spawn leaves reached_end=1.
- Reset_h pulsed mid-DYING -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/zombie_layer.sv
// zombie_layer: one zombie sprite for the lawn. Runs the IDLE/WALK/EAT/DYING
// life-cycle on frame pulses, and produces the sprite ROM address and the
// layer-valid flag for the pixel currently being drawn.
//
// Ports:
//   CLK, Reset_h         pixel-domain clock, asynchronous active-high reset
//   frame_start          one-cycle pulse per video frame
//   DrawX, DrawY         current pixel coordinates
//   spawn, spawn_row     spawn request and target row (0-4)
//   hit                  one-cycle pea hit pulse
//   blocked              level, a plant occupies the cell in front
//   read_address_zom     sprite ROM address, 1 cycle after DrawX/DrawY
//   zom_on               layer valid, 2 cycles after DrawX/DrawY (ROM aligned)
//   zom_x, zom_row       current position
//   zom_state            0 IDLE, 1 WALK, 2 EAT, 3 DYING
//   reached_end          sticky game-over flag
module zombie_layer #(
  parameter int unsigned ZOM_W       = 64,
  parameter int unsigned ZOM_H       = 80,
  parameter int unsigned START_X     = 640,
  parameter int unsigned END_X       = 40,
  parameter int unsigned ROW_Y0      = 80,
  parameter int unsigned ROW_PITCH   = 96,
  parameter int unsigned STEP_FRAMES = 4,
  parameter int unsigned HP_INIT     = 10,
  parameter int unsigned DEAD_FRAMES = 30
) (
  input  logic        CLK,
  input  logic        Reset_h,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        spawn,
  input  logic [2:0]  spawn_row,
  input  logic        hit,
  input  logic        blocked,
  output logic [18:0] read_address_zom,
  output logic        zom_on,
  output logic [9:0]  zom_x,
  output logic [2:0]  zom_row,
  output logic [1:0]  zom_state,
  output logic        reached_end
);

  localparam int unsigned XW = 10;  // screen coordinate width
  localparam int unsigned RW = 3;   // row index width
  localparam int unsigned AW = 19;  // ROM address width
  localparam int unsigned CW = 8;   // hp / frame counter width
  localparam int unsigned PW = 11;  // widened compare width, avoids wrap at x>=640

  localparam logic [AW-1:0] EAT_BASE = AW'(ZOM_W * ZOM_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WALK  = 2'd1,
    S_EAT   = 2'd2,
    S_DYING = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  hp_q, hp_d;
  logic [CW-1:0]  step_q, step_d;
  logic [CW-1:0]  dead_q, dead_d;
  logic           end_q, end_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           on1_q, on1_d;
  logic           on2_q;

  // Life-cycle state register
  always_ff @(posedge CLK or posedge Reset_h) begin
    if (Reset_h) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      row_q   <= '0;
      hp_q    <= '0;
      step_q  <= '0;
      dead_q  <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      row_q   <= row_d;
      hp_q    <= hp_d;
      step_q  <= step_d;
      dead_q  <= dead_d;
      end_q   <= end_d;
    end
  end

  // Next-state: a killing hit outranks reaching the house, blocking and movement
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    row_d   = row_q;
    hp_d    = hp_q;
    step_d  = step_q;
    dead_d  = dead_q;
    end_d   = end_q;
    case (state_q)
      S_IDLE: begin
        if (spawn && (spawn_row <= RW'(4))) begin
          x_d     = XW'(START_X);
          row_d   = spawn_row;
          hp_d    = CW'(HP_INIT);
          step_d  = '0;
          state_d = S_WALK;
        end
      end
      S_WALK, S_EAT: begin
        if (hit && (hp_q <= CW'(1))) begin
          hp_d    = '0;
          dead_d  = '0;
          state_d = S_DYING;
        end else begin
          if (hit) hp_d = hp_q - CW'(1);
          if (state_q == S_WALK) begin
            if (x_q <= XW'(END_X)) begin
              end_d   = 1'b1;
              state_d = S_IDLE;
            end else if (blocked) begin
              state_d = S_EAT;
            end else if (frame_start) begin
              if (step_q == CW'(STEP_FRAMES - 1)) begin
                step_d = '0;
                x_d    = x_q - XW'(1);
              end else begin
                step_d = step_q + CW'(1);
              end
            end
          end else if (!blocked) begin
            state_d = S_WALK;  // step_q was held, so the step phase resumes
          end
        end
      end
      S_DYING: begin
        if (frame_start) begin
          if (dead_q == CW'(DEAD_FRAMES - 1)) state_d = S_IDLE;
          else                                dead_d  = dead_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [PW-1:0] row_y, px, py, dx, dy;
  logic          in_box;

  // Bounding box test and sprite-relative address for the current pixel
  always_comb begin
    row_y  = PW'(ROW_Y0) + PW'(row_q) * PW'(ROW_PITCH);
    px     = PW'(DrawX);
    py     = PW'(DrawY);
    dx     = px - PW'(x_q);
    dy     = py - row_y;
    in_box = (px >= PW'(x_q)) && (px < PW'(x_q) + PW'(ZOM_W)) &&
             (py >= row_y)    && (py < row_y + PW'(ZOM_H));
    addr_d = '0;
    if (in_box) begin
      addr_d = AW'(dy) * AW'(ZOM_W) + AW'(dx) + ((state_q == S_EAT) ? EAT_BASE : '0);
    end
    on1_d = in_box && (state_q != S_IDLE);
  end

  // Pixel pipeline: address after 1 cycle, valid after 2 to meet ROM data
  always_ff @(posedge CLK or posedge Reset_h) begin
    if (Reset_h) begin
      addr_q <= '0;
      on1_q  <= 1'b0;
      on2_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      on1_q  <= on1_d;
      on2_q  <= on1_q;
    end
  end

  assign read_address_zom = addr_q;
  assign zom_on           = on2_q;
  assign zom_x            = x_q;
  assign zom_row          = row_q;
  assign zom_state        = state_q;
  assign reached_end      = end_q;

endmodule

// File: tb/tb_zombie_layer.sv
// Directed bench for zombie_layer; expectations go through a scoreboard queue.
module tb_zombie_layer;

  logic        CLK = 1'b0;
  logic        Reset_h = 1'b1;
  logic        frame_start = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        spawn = 1'b0;
  logic [2:0]  spawn_row = '0;
  logic        hit = 1'b0;
  logic        blocked = 1'b0;
  logic [18:0] read_address_zom;
  logic        zom_on;
  logic [9:0]  zom_x;
  logic [2:0]  zom_row;
  logic [1:0]  zom_state;
  logic        reached_end;

  zombie_layer dut (
    .CLK              (CLK),
    .Reset_h          (Reset_h),
    .frame_start      (frame_start),
    .DrawX            (DrawX),
    .DrawY            (DrawY),
    .spawn            (spawn),
    .spawn_row        (spawn_row),
    .hit              (hit),
    .blocked          (blocked),
    .read_address_zom (read_address_zom),
    .zom_on           (zom_on),
    .zom_x            (zom_x),
    .zom_row          (zom_row),
    .zom_state        (zom_state),
    .reached_end      (reached_end)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty: observed %0d with no expected entry", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] val);
    push(tag, val);
    pop_cmp(obs);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1;
      tick();
      hit = 1'b0;
    end
  endtask

  task automatic do_spawn(input logic [2:0] r);
    spawn_row = r;
    spawn = 1'b1;
    tick();
    spawn = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    chk("rst_state", zom_state, 0);
    chk("rst_x", zom_x, 0);
    chk("rst_end", reached_end, 0);
    chk("rst_on", zom_on, 0);
    chk("rst_addr", read_address_zom, 0);
    Reset_h = 1'b0;
    tick();

    // Out-of-range row is ignored
    do_spawn(3'd5);
    chk("bad_row_state", zom_state, 0);

    // Spawn on row 2, walk 8 frames
    do_spawn(3'd2);
    chk("spawn_state", zom_state, 1);
    chk("spawn_x", zom_x, 640);
    chk("spawn_row", zom_row, 2);
    frames(8);
    chk("walk8_x", zom_x, 638);
    chk("walk8_state", zom_state, 1);

    // Two more frames leave step phase at 2, then block
    frames(2);
    blocked = 1'b1;
    tick();
    chk("eat_state", zom_state, 2);
    frames(10);
    chk("eat_x_hold", zom_x, 638);
    chk("eat_state_hold", zom_state, 2);

    // Eating sprite address: row 2 -> row_y 272; box edge at x=638 does not wrap
    DrawX = 10'd638;
    DrawY = 10'd272;
    push("eat_addr", 5120);
    tick();
    pop_cmp(read_address_zom);
    push("eat_on", 1);
    tick();
    pop_cmp(zom_on);
    DrawX = '0;
    DrawY = '0;

    // Unblock: resume from held step phase (2): one frame no move, next moves
    blocked = 1'b0;
    tick();
    chk("unblock_state", zom_state, 1);
    frames(1);
    chk("resume1_x", zom_x, 638);
    frames(1);
    chk("resume2_x", zom_x, 637);

    // Hits: first coincides with frame_start, both must act
    frame_start = 1'b1;
    hits(1);
    frame_start = 1'b0;
    hits(4);
    chk("hit5_state", zom_state, 1);
    blocked = 1'b1;
    tick();
    hits(4);
    chk("hit9_state", zom_state, 2);
    hits(1);
    chk("hit10_dying", zom_state, 3);
    blocked = 1'b0;
    hits(1);
    chk("hit11_dying", zom_state, 3);
    frames(29);
    chk("dying29", zom_state, 3);
    frames(1);
    chk("dying30_idle", zom_state, 0);
    hits(1);
    chk("hit_idle", zom_state, 0);

    // Pixel pipeline at x=600, row 0
    do_spawn(3'd0);
    frames(160);
    chk("pix_x", zom_x, 600);
    DrawX = 10'd610;
    DrawY = 10'd90;
    push("pix_addr", 650);
    push("pix_on_lat1", 0);
    tick();
    pop_cmp(read_address_zom);
    pop_cmp(zom_on);
    push("pix_on", 1);
    tick();
    pop_cmp(zom_on);
    DrawX = 10'd599;
    push("pix_out_addr", 0);
    tick();
    pop_cmp(read_address_zom);
    push("pix_out_on", 0);
    tick();
    pop_cmp(zom_on);
    DrawX = '0;
    DrawY = '0;

    // Walk to the house (bounded)
    for (int i = 0; i < 3000 && zom_state != 2'd0; i++) frames(1);
    chk("end_state", zom_state, 0);
    chk("end_x", zom_x, 40);
    chk("end_flag", reached_end, 1);
    do_spawn(3'd1);
    chk("respawn_state", zom_state, 1);
    chk("respawn_end", reached_end, 1);

    // Kill on row 1 at x=640, check DYING address base and valid
    hits(10);
    chk("kill2_state", zom_state, 3);
    DrawX = 10'd650;
    DrawY = 10'd180;
    push("dying_addr", 266);
    tick();
    pop_cmp(read_address_zom);
    push("dying_on", 1);
    tick();
    pop_cmp(zom_on);
    frames(3);

    // Asynchronous reset mid-DYING, sampled before any clock edge
    Reset_h = 1'b1;
    #1;
    chk("arst_state", zom_state, 0);
    chk("arst_x", zom_x, 0);
    chk("arst_row", zom_row, 0);
    chk("arst_end", reached_end, 0);
    chk("arst_on", zom_on, 0);
    chk("arst_addr", read_address_zom, 0);
    tick();
    Reset_h = 1'b0;
    DrawX = '0;
    DrawY = '0;
    tick();

    // Normal operation after reset release
    do_spawn(3'd3);
    chk("post_state", zom_state, 1);
    chk("post_row", zom_row, 3);
    chk("post_x", zom_x, 640);
    chk("post_end", reached_end, 0);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
